qpll_reconfig_sequencer: RTL and testbench

// Runtime line-rate reconfiguration of one QPLL in the GTY QuadPLL over its APB management port.
// On each accepted request the block:
//   - holds the selected QPLL in reset
//   - read-modify-writes the FBDIV field
//   - releases reset
//   - waits for lock, with timeout and bounded retry

---
 rtl/qpll_seq_pkg.sv | 50 +++++
 rtl/apb_single_transfer.sv | 96 +++++++++
 rtl/qpll_reconfig_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_qpll_reconfig_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/qpll_seq_pkg.sv
// Shared types, limits and helpers for the QPLL line-rate reconfiguration sequencer.
package qpll_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_REJECT     = 4'd1,
    S_ASSERT_RST = 4'd2,
    S_RD_SETUP   = 4'd3,
    S_RD_ACCESS  = 4'd4,
    S_WR_SETUP   = 4'd5,
    S_WR_ACCESS  = 4'd6,
    S_RELEASE    = 4'd7,
    S_WAIT_LOCK  = 4'd8,
    S_DONE       = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_SLVERR  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } seq_err_t;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_t;

  localparam logic [7:0] FBDIV_MIN    = 8'd16;
  localparam logic [7:0] FBDIV_MAX    = 8'd160;
  localparam logic [7:0] FBDIV_OFFSET = 8'd2;

  function automatic logic fbdiv_in_range(input logic [7:0] mult);
    return (mult >= FBDIV_MIN) && (mult <= FBDIV_MAX);
  endfunction

  function automatic logic [1:0] pll_mask(input logic pll);
    return pll ? 2'b10 : 2'b01;
  endfunction

  // The PLL stays in reset from the hold phase until the FBDIV write completes.
  function automatic logic holds_reset(input seq_state_t st);
    case (st)
      S_ASSERT_RST, S_RD_SETUP, S_RD_ACCESS, S_WR_SETUP, S_WR_ACCESS: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_single_transfer.sv
// One APB transfer per start pulse; a new start is accepted while idle or on the
// completing pready cycle, so the next SETUP directly follows the previous ACCESS.
module apb_single_transfer
  import qpll_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  addr,
  input  logic        write,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        slverr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [9:0]  paddr,
  output logic [15:0] pwdata,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  apb_state_t  state_r;
  apb_state_t  state_next_s;
  logic        load_s;
  logic        psel_r;
  logic        penable_r;
  logic        pwrite_r;
  logic [9:0]  paddr_r;
  logic [15:0] pwdata_r;

  // Next APB phase and request capture
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      APB_IDLE: begin
        if (start) begin
          state_next_s = APB_SETUP;
          load_s       = 1'b1;
        end else begin
          state_next_s = APB_IDLE;
        end
      end
      APB_SETUP: state_next_s = APB_ACCESS;
      APB_ACCESS: begin
        if (pready && start) begin
          state_next_s = APB_SETUP;
          load_s       = 1'b1;
        end else if (pready) begin
          state_next_s = APB_IDLE;
        end else begin
          state_next_s = APB_ACCESS;
        end
      end
      default: state_next_s = APB_IDLE;
    endcase
  end

  // APB phase register
  always_ff @(posedge clk) begin
    if (rst) state_r <= APB_IDLE;
    else     state_r <= state_next_s;
  end

  // Registered bus outputs; address/direction/data held until the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= 10'd0;
      pwdata_r  <= 16'd0;
    end else begin
      psel_r    <= (state_next_s != APB_IDLE);
      penable_r <= (state_next_s == APB_ACCESS);
      if (load_s) begin
        paddr_r  <= addr;
        pwrite_r <= write;
      end
      if (load_s && write) pwdata_r <= wdata;
    end
  end

  assign done    = (state_r == APB_ACCESS) && pready;
  assign slverr  = done && pslverr;
  assign rdata   = prdata;
  assign psel    = psel_r;
  assign penable = penable_r;
  assign pwrite  = pwrite_r;
  assign paddr   = paddr_r;
  assign pwdata  = pwdata_r;

endmodule

// File: rtl/qpll_reconfig_sequencer.sv
// Runtime QPLL line-rate change: hold PLL in reset, read-modify-write FBDIV over APB,
// release and wait for lock with timeout and bounded retry.
module qpll_reconfig_sequencer
  import qpll_seq_pkg::*;
#(
  parameter logic [9:0]  FBDIV_ADDR0  = 10'h014,
  parameter logic [9:0]  FBDIV_ADDR1  = 10'h094,
  parameter int unsigned RESET_CYCLES = 32'd32,
  parameter int unsigned LOCK_TIMEOUT = 32'd156250,
  parameter int unsigned MAX_RETRIES  = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_pll,
  input  logic [7:0]  req_mult,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [1:0]  qpll_reset,
  input  logic [1:0]  qpll_lock,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [9:0]  paddr,
  output logic [15:0] pwdata,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 32'd1;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

  seq_state_t       state_r, state_next_s;
  seq_err_t         err_r, err_next_s, err_out_r;
  logic             pll_r, pll_next_s;
  logic [7:0]       mult_r, mult_next_s;
  logic [1:0]       retry_r, retry_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, done_r, idle_r;
  logic [1:0]       qpll_reset_r;

  logic             apb_start_s, apb_write_s, apb_done_s, apb_slverr_s;
  logic [9:0]       apb_addr_s;
  logic [15:0]      apb_wdata_s, apb_rdata_s;
  logic [7:0]       rd_fbdiv_unused_s;
  logic             target_lock_s;

  assign apb_addr_s        = pll_r ? FBDIV_ADDR1 : FBDIV_ADDR0;
  assign apb_wdata_s       = {apb_rdata_s[15:8], mult_r - FBDIV_OFFSET};
  assign rd_fbdiv_unused_s = apb_rdata_s[7:0];
  assign target_lock_s     = qpll_lock[pll_r];

  // Sequencer next state, request context and APB commands
  always_comb begin
    state_next_s = state_r;
    err_next_s   = err_r;
    pll_next_s   = pll_r;
    mult_next_s  = mult_r;
    retry_next_s = retry_r;
    apb_start_s  = 1'b0;
    apb_write_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          pll_next_s   = req_pll;
          mult_next_s  = req_mult;
          retry_next_s = 2'd0;
          if (fbdiv_in_range(req_mult)) begin
            err_next_s   = ERR_NONE;
            state_next_s = S_ASSERT_RST;
          end else begin
            err_next_s   = ERR_RANGE;
            state_next_s = S_REJECT;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REJECT: state_next_s = S_DONE;
      S_ASSERT_RST: begin
        if (cnt_r == RST_LAST) begin
          // Retries only re-pulse reset; FBDIV was already written.
          if (retry_r == 2'd0) begin
            state_next_s = S_RD_SETUP;
            apb_start_s  = 1'b1;
          end else begin
            state_next_s = S_RELEASE;
          end
        end else begin
          state_next_s = S_ASSERT_RST;
        end
      end
      S_RD_SETUP: state_next_s = S_RD_ACCESS;
      S_RD_ACCESS: begin
        if (apb_done_s && apb_slverr_s) begin
          err_next_s   = ERR_SLVERR;
          state_next_s = S_RELEASE;
        end else if (apb_done_s) begin
          state_next_s = S_WR_SETUP;
          apb_start_s  = 1'b1;
          apb_write_s  = 1'b1;
        end else begin
          state_next_s = S_RD_ACCESS;
        end
      end
      S_WR_SETUP: state_next_s = S_WR_ACCESS;
      S_WR_ACCESS: begin
        if (apb_done_s) begin
          err_next_s   = apb_slverr_s ? ERR_SLVERR : err_r;
          state_next_s = S_RELEASE;
        end else begin
          state_next_s = S_WR_ACCESS;
        end
      end
      S_RELEASE: begin
        if (err_r == ERR_SLVERR) state_next_s = S_DONE;
        else                     state_next_s = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (target_lock_s) begin
          state_next_s = S_DONE;
        end else if (cnt_r == LOCK_LAST) begin
          if (retry_r == RETRY_LIMIT) begin
            err_next_s   = ERR_TIMEOUT;
            state_next_s = S_DONE;
          end else begin
            retry_next_s = retry_r + 2'd1;
            state_next_s = S_ASSERT_RST;
          end
        end else begin
          state_next_s = S_WAIT_LOCK;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, context and shared wait counter (cleared on every state entry)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      err_r   <= ERR_NONE;
      pll_r   <= 1'b0;
      mult_r  <= 8'd0;
      retry_r <= 2'd0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      err_r   <= err_next_s;
      pll_r   <= pll_next_s;
      mult_r  <= mult_next_s;
      retry_r <= retry_next_s;
      if ((state_next_s != state_r) || (state_r == S_IDLE)) cnt_r <= {CNT_W{1'b0}};
      else                                                    cnt_r <= cnt_r + CNT_W'(32'd1);
    end
  end

  // Registered status and PLL reset outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_r       <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_out_r    <= ERR_NONE;
      qpll_reset_r <= 2'b00;
    end else begin
      idle_r       <= (state_next_s == S_IDLE);
      busy_r       <= (state_next_s != S_IDLE);
      done_r       <= (state_next_s == S_DONE);
      err_out_r    <= (state_next_s == S_DONE) ? err_next_s : ERR_NONE;
      qpll_reset_r <= holds_reset(state_next_s) ? pll_mask(pll_next_s) : 2'b00;
    end
  end

  apb_single_transfer u_apb (
    .clk     (clk),
    .rst     (rst),
    .start   (apb_start_s),
    .addr    (apb_addr_s),
    .write   (apb_write_s),
    .wdata   (apb_wdata_s),
    .done    (apb_done_s),
    .rdata   (apb_rdata_s),
    .slverr  (apb_slverr_s),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  assign req_ready  = idle_r & ~rst;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_out_r;
  assign qpll_reset = qpll_reset_r;

endmodule

// File: tb/tb_qpll_reconfig_sequencer.sv
// Directed bench for qpll_reconfig_sequencer with an APB completer model, a lock model
// and per-request observation counters.
module tb_qpll_reconfig_sequencer;

  localparam int LOCK_T = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_pll;
  logic [7:0]  req_mult;
  logic        busy, done;
  logic [1:0]  err, qpll_reset, qpll_lock;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [9:0]  paddr;
  logic [15:0] pwdata, prdata;

  int n_checks = 0;
  int n_pass   = 0;

  int          ws_cfg = 0;
  logic [15:0] rd_val = 16'h0000;
  logic        slverr_rd = 1'b0;
  int          lock_delay = 0;

  int          rst_hi0 = 0, rst_hi1 = 0, rst_pulses = 0, n_rd = 0, n_wr = 0;
  int          stab_err = 0, wait_cyc = 0, psel_cyc = 0;
  logic [9:0]  rd_addr = 10'd0, wr_addr = 10'd0;
  logic [15:0] wr_data = 16'd0;

  qpll_reconfig_sequencer #(
    .RESET_CYCLES (32),
    .LOCK_TIMEOUT (LOCK_T),
    .MAX_RETRIES  (2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pll(req_pll), .req_mult(req_mult), .busy(busy), .done(done), .err(err),
    .qpll_reset(qpll_reset), .qpll_lock(qpll_lock), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Completer, lock model and monitors, evaluated on the falling edge
  initial begin : models
    int ws;
    int lcnt;
    logic [1:0]  prev_rst;
    logic [9:0]  s_addr;
    logic        s_write;
    logic [15:0] s_wdata;
    ws = 0; lcnt = 0; prev_rst = 2'b00;
    s_addr = 10'd0; s_write = 1'b0; s_wdata = 16'd0;
    pready = 1'b0; pslverr = 1'b0; prdata = 16'd0; qpll_lock = 2'b00;
    forever begin
      @(negedge clk);
      if (qpll_reset[0]) rst_hi0++;
      if (qpll_reset[1]) rst_hi1++;
      if ((qpll_reset != 2'b00) && (prev_rst == 2'b00)) rst_pulses++;
      prev_rst = qpll_reset;
      if (psel) psel_cyc++;
      if (busy && !done && !psel && (qpll_reset == 2'b00)) wait_cyc++;
      if (psel && !penable) begin
        s_addr = paddr; s_write = pwrite; s_wdata = pwdata;
      end
      if (psel && penable && ((paddr != s_addr) || (pwrite != s_write) || (pwdata != s_wdata)))
        stab_err++;
      if (psel && penable) begin
        if (ws >= ws_cfg) begin
          pready = 1'b1; ws = 0;
          if (pwrite) begin
            n_wr++; wr_addr = paddr; wr_data = pwdata; pslverr = 1'b0; prdata = 16'd0;
          end else begin
            n_rd++; rd_addr = paddr; prdata = rd_val; pslverr = slverr_rd;
          end
        end else begin
          pready = 1'b0; pslverr = 1'b0; ws++;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; ws = 0;
      end
      if (qpll_reset != 2'b00) begin
        lcnt = 0; qpll_lock = 2'b00;
      end else begin
        lcnt++;
        qpll_lock = ((lock_delay >= 0) && (lcnt > lock_delay)) ? 2'b11 : 2'b00;
      end
    end
  end

  task automatic run_req(input string tag, input logic pll, input logic [7:0] mult,
                         input int exp_lat, input logic [1:0] exp_err);
    int   lat;
    logic seen;
    rst_hi0 = 0; rst_hi1 = 0; rst_pulses = 0; n_rd = 0; n_wr = 0;
    stab_err = 0; wait_cyc = 0; psel_cyc = 0;
    check_val({tag, " ready"}, req_ready, 1);
    req_valid = 1'b1; req_pll = pll; req_mult = mult;
    @(negedge clk);
    req_valid = 1'b0;
    check_val({tag, " busy"}, busy, 1);
    lat = 1; seen = done;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      seen = done;
    end
    check_val({tag, " done"}, seen, 1);
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " err"}, err, exp_err);
    check_val({tag, " rst at done"}, qpll_reset, 0);
  endtask

  initial begin : stim
    int k;
    int n_done;
    rst = 1'b1; req_valid = 1'b0; req_pll = 1'b0; req_mult = 8'd0;
    repeat (3) @(negedge clk);
    check_val("reset ctl", {req_ready, busy, done, err, qpll_reset, psel, penable, pwrite}, 0);
    check_val("reset paddr", paddr, 0);
    check_val("reset pwdata", pwdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle ready", req_ready, 1);

    // Basic reconfiguration of QPLL0, lock 10 cycles after release
    ws_cfg = 0; rd_val = 16'hAB40; slverr_rd = 1'b0; lock_delay = 10;
    run_req("t1", 1'b0, 8'd66, 48, 2'd0);
    check_val("t1 rst0 cycles", rst_hi0, 36);
    check_val("t1 rst1 cycles", rst_hi1, 0);
    check_val("t1 reads", n_rd, 1);
    check_val("t1 writes", n_wr, 1);
    check_val("t1 rd addr", rd_addr, 10'h014);
    check_val("t1 wr addr", wr_addr, 10'h014);
    check_val("t1 wdata", wr_data, 16'hAB40);
    @(negedge clk);
    check_val("t1 busy clear", {busy, done, req_ready}, 3'b001);

    // QPLL1 with three wait states per access
    ws_cfg = 3; rd_val = 16'h5A77; lock_delay = 0;
    run_req("t2", 1'b1, 8'd64, 45, 2'd0);
    check_val("t2 rd addr", rd_addr, 10'h094);
    check_val("t2 wr addr", wr_addr, 10'h094);
    check_val("t2 wdata", wr_data, 16'h5A3E);
    check_val("t2 stable", stab_err, 0);
    check_val("t2 rst0 cycles", rst_hi0, 0);
    check_val("t2 rst1 cycles", rst_hi1, 42);
    @(negedge clk);

    // Range rejection and boundaries
    ws_cfg = 0; rd_val = 16'h1234;
    run_req("t3 200", 1'b0, 8'd200, 2, 2'd1);
    check_val("t3 no psel", psel_cyc, 0);
    check_val("t3 no reset", rst_hi0 + rst_hi1, 0);
    @(negedge clk);
    run_req("t3 161", 1'b1, 8'd161, 2, 2'd1);
    check_val("t3 161 no psel", psel_cyc, 0);
    @(negedge clk);
    run_req("t3 15", 1'b0, 8'd15, 2, 2'd1);
    @(negedge clk);
    run_req("t3 16", 1'b0, 8'd16, 39, 2'd0);
    check_val("t3 16 wdata", wr_data, 16'h120E);
    @(negedge clk);
    run_req("t3 160", 1'b1, 8'd160, 39, 2'd0);
    check_val("t3 160 wdata", wr_data, 16'h129E);
    @(negedge clk);

    // Slave error on the read
    slverr_rd = 1'b1;
    run_req("t4", 1'b0, 8'd80, 36, 2'd2);
    check_val("t4 reads", n_rd, 1);
    check_val("t4 writes", n_wr, 0);
    check_val("t4 rst0 cycles", rst_hi0, 34);
    slverr_rd = 1'b0;
    @(negedge clk);

    // Lock never asserts: two retries then timeout
    lock_delay = -1;
    run_req("t5", 1'b1, 8'd100, 104 + 3 * LOCK_T, 2'd3);
    check_val("t5 pulses", rst_pulses, 3);
    check_val("t5 reads", n_rd, 1);
    check_val("t5 writes", n_wr, 1);
    check_val("t5 wait cycles", wait_cyc, 3 * LOCK_T + 3);
    check_val("t5 rst0 cycles", rst_hi0, 0);
    check_val("t5 rst1 cycles", rst_hi1, 100);
    @(negedge clk);

    // Reset during the write access, then a fresh request
    lock_delay = 0; ws_cfg = 3; rd_val = 16'hAB40;
    req_valid = 1'b1; req_pll = 1'b0; req_mult = 8'd66;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!(psel && penable && pwrite) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("t6 reach wr access", psel && penable && pwrite, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t6 abort ctl", {busy, done, err, qpll_reset, psel, penable, pwrite}, 0);
    check_val("t6 abort paddr", paddr, 0);
    check_val("t6 abort pwdata", pwdata, 0);
    check_val("t6 abort ready", req_ready, 1);
    n_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_val("t6 no done", n_done, 0);
    ws_cfg = 0; lock_delay = 10;
    run_req("t6 fresh", 1'b0, 8'd66, 48, 2'd0);
    check_val("t6 fresh wdata", wr_data, 16'hAB40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
